// File: rtl/lcd_write_arbiter.sv
// Grants the single lcd_write word engine to one requester for a whole locked
// transaction: fixed-priority init source, round-robin for the rest, per-word watchdog.
module lcd_write_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [9*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   gnt,
  output logic [8:0]        spi_data,
  output logic              en_write,
  input  logic              wr_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned WORD_W = 9;
  localparam int unsigned OW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WDW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_TRIP = WDW'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, OWN, WAIT, RELEASE} state_t;

  state_t            state;
  logic [OW-1:0]     owner;
  logic [OW-1:0]     last_owner;
  logic [WDW-1:0]    wdog;
  logic [OW-1:0]     rr_idx;
  logic              rr_hit;
  logic [WORD_W-1:0] words [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = req_data[WORD_W*g +: WORD_W];
  end

  // Round-robin over requesters 1..NREQ-1, starting after the last owner.
  always_comb begin
    int unsigned start;
    int unsigned pos;
    start  = 32'(last_owner) + 32'd1;
    pos    = 0;
    rr_idx = '0;
    rr_hit = 1'b0;
    if (start >= NREQ) start = 1;
    for (int unsigned k = 0; k < NREQ - 1; k++) begin
      pos = start + k;
      if (pos >= NREQ) pos = pos - (NREQ - 1);
      if (!rr_hit && req[OW'(pos)]) begin
        rr_hit = 1'b1;
        rr_idx = OW'(pos);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      owner       <= '0;
      last_owner  <= OW'(NREQ - 1);
      wdog        <= '0;
      gnt         <= '0;
      req_ready   <= '0;
      spi_data    <= '0;
      en_write    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      en_write  <= 1'b0;
      req_ready <= '0;
      unique case (state)
        IDLE: begin
          if (req[0]) begin
            owner <= '0;
            gnt   <= NREQ'(1);
            busy  <= 1'b1;
            state <= OWN;
          end else if (rr_hit) begin
            owner <= rr_idx;
            gnt   <= NREQ'(1) << rr_idx;
            busy  <= 1'b1;
            state <= OWN;
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end
        OWN: begin
          if (!req[owner]) begin
            state <= RELEASE;
          end else if (req_valid[owner]) begin
            spi_data <= words[owner];
            en_write <= 1'b1;
            wdog     <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // In-flight word always finishes or times out, even if req drops.
          if (wr_done) begin
            req_ready <= gnt;
            state     <= OWN;
          end else begin
            if (wdog != WD_LAST) wdog <= wdog + WDW'(1);
            if (wdog == WD_TRIP) begin
              timeout_err <= 1'b1;
              state       <= RELEASE;
            end
          end
        end
        RELEASE: begin
          gnt        <= '0;
          last_owner <= owner;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: cycle vector table plus hand-written
// transaction sequences driven against a simple lcd_write response model.
module tb_lcd_write_arbiter;

  logic       clk;
  logic       sys_rst;
  logic [2:0] req;
  logic [2:0] req_valid;
  logic [8:0] rdata [3];
  logic [26:0] req_data;
  logic       done_tbl;
  logic       wr_model;
  logic       wr_done;

  logic [2:0] rdy_m, gnt_m, rdy_t, gnt_t;
  logic [8:0] spi_m, spi_t;
  logic       en_m, en_t, busy_m, busy_t, terr_m, terr_t;

  logic       use_t;
  logic       noise;
  int         wr_lat;
  int         checks;
  int         errors;

  logic [2:0] s_gnt, s_rdy;
  logic [8:0] s_spi;
  logic       s_en, s_busy, s_terr;

  assign req_data = {rdata[2], rdata[1], rdata[0]};
  assign wr_done  = done_tbl | wr_model;
  assign s_gnt    = use_t ? gnt_t  : gnt_m;
  assign s_rdy    = use_t ? rdy_t  : rdy_m;
  assign s_spi    = use_t ? spi_t  : spi_m;
  assign s_en     = use_t ? en_t   : en_m;
  assign s_busy   = use_t ? busy_t : busy_m;
  assign s_terr   = use_t ? terr_t : terr_m;

  lcd_write_arbiter #(.NREQ(3), .TIMEOUT(64)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .req(req), .req_valid(req_valid),
    .req_data(req_data), .req_ready(rdy_m), .gnt(gnt_m), .spi_data(spi_m),
    .en_write(en_m), .wr_done(wr_done), .busy(busy_m), .timeout_err(terr_m)
  );

  lcd_write_arbiter #(.NREQ(3), .TIMEOUT(16)) dut_t (
    .sys_clk(clk), .sys_rst(sys_rst), .req(req), .req_valid(req_valid),
    .req_data(req_data), .req_ready(rdy_t), .gnt(gnt_t), .spi_data(spi_t),
    .en_write(en_t), .wr_done(wr_done), .busy(busy_t), .timeout_err(terr_t)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // lcd_write model: wr_done pulse wr_lat cycles after en_write; 0 = never answers.
  initial begin : writer
    int cnt;
    cnt      = 0;
    wr_model = 1'b0;
    forever begin
      @(posedge clk); #1;
      wr_model = 1'b0;
      if (wr_lat == 0) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) wr_model = 1'b1;
        end
        if (s_en) cnt = wr_lat;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  typedef struct packed {
    logic       rst;
    logic [2:0] req;
    logic [2:0] vld;
    logic       done;
    logic [2:0] gnt;
    logic       en;
    logic [2:0] rdy;
    logic [8:0] spi;
    logic       busy;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(input logic rst, input logic [2:0] rq, input logic [2:0] vl,
                              input logic dn, input logic [2:0] g, input logic en,
                              input logic [2:0] rd, input logic [8:0] spi, input logic bz);
    vec_t v;
    v.rst = rst; v.req = rq; v.vld = vl; v.done = dn;
    v.gnt = g; v.en = en; v.rdy = rd; v.spi = spi; v.busy = bz;
    return v;
  endfunction

  function automatic logic [2:0] oh(input logic [1:0] i);
    return 3'(1) << i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    wr_lat    = 0;
    req       = '0;
    req_valid = '0;
    sys_rst   = 1'b1;
    tick();
    sys_rst   = 1'b0;
  endtask

  // One word from requester idx; checks issue, data stability, ownership and completion timing.
  task automatic xfer(input logic [1:0] idx, input logic [8:0] w, input int lat);
    int         cyc, en_cnt, en_at, rdy_at;
    logic       prev_done, got, gnt_ok, spi_ok;
    logic [1:0] oth;
    oth = (idx == 2'd1) ? 2'd2 : 2'd1;
    rdata[idx] = w;
    req_valid[idx] = 1'b1;
    cyc = 0; en_cnt = 0; en_at = -1; rdy_at = -1;
    prev_done = 1'b0; got = 1'b0; gnt_ok = 1'b1; spi_ok = 1'b1;
    while (!got && cyc < 200) begin
      tick();
      cyc++;
      if (s_en) begin
        en_cnt++;
        en_at = cyc;
      end
      if (en_at >= 0 && s_spi !== w) spi_ok = 1'b0;
      if (s_gnt !== oh(idx)) gnt_ok = 1'b0;
      if (s_rdy !== 3'b000) begin
        got    = 1'b1;
        rdy_at = cyc;
        chk("rdy_onehot", 32'(s_rdy), 32'(oh(idx)));
        chk("rdy_after_done", 32'(prev_done), 32'd1);
      end
      prev_done = wr_done;
      if (noise) begin
        req_valid[oth] = ~req_valid[oth];
        rdata[oth]     = rdata[oth] ^ 9'h1FF;
      end
    end
    chk("ready_seen", 32'(got), 32'd1);
    chk("en_pulses", 32'(en_cnt), 32'd1);
    chk("word_latency", 32'(rdy_at - en_at), 32'(lat + 1));
    chk("spi_data_stable", 32'(spi_ok), 32'd1);
    chk("gnt_held", 32'(gnt_ok), 32'd1);
    req_valid[idx] = 1'b0;
    if (noise) req_valid[oth] = 1'b0;
  endtask

  task automatic release_chk(input logic [1:0] idx, input logic reraise, input logic [2:0] nxt);
    req[idx] = 1'b0;
    tick();
    chk("rel_gnt", 32'(s_gnt), 32'(oh(idx)));
    chk("rel_busy", 32'(s_busy), 32'd1);
    tick();
    chk("idle_gnt", 32'(s_gnt), 32'd0);
    chk("idle_busy", 32'(s_busy), 32'd0);
    if (reraise) req[idx] = 1'b1;
    tick();
    chk("next_gnt", 32'(s_gnt), 32'(nxt));
    chk("next_busy", 32'(s_busy), 32'(nxt != 3'b000));
  endtask

  initial begin
    logic bad;
    checks = 0; errors = 0;
    sys_rst = 1'b1; req = '0; req_valid = '0; done_tbl = 1'b0;
    use_t = 1'b0; noise = 1'b0; wr_lat = 0;
    rdata[0] = 9'h155; rdata[1] = 9'h0C3; rdata[2] = 9'h1E0;

    // rst req vld done | gnt en rdy spi busy
    vt[0]  = mk(1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 9'h000, 1'b0);
    vt[1]  = mk(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 9'h000, 1'b0);
    vt[2]  = mk(1'b0, 3'b101, 3'b000, 1'b0, 3'b001, 1'b0, 3'b000, 9'h000, 1'b1);
    vt[3]  = mk(1'b0, 3'b101, 3'b001, 1'b0, 3'b001, 1'b1, 3'b000, 9'h155, 1'b1);
    vt[4]  = mk(1'b0, 3'b101, 3'b001, 1'b0, 3'b001, 1'b0, 3'b000, 9'h155, 1'b1);
    vt[5]  = mk(1'b0, 3'b101, 3'b001, 1'b1, 3'b001, 1'b0, 3'b001, 9'h155, 1'b1);
    vt[6]  = mk(1'b0, 3'b101, 3'b000, 1'b0, 3'b001, 1'b0, 3'b000, 9'h155, 1'b1);
    vt[7]  = mk(1'b0, 3'b100, 3'b000, 1'b0, 3'b001, 1'b0, 3'b000, 9'h155, 1'b1);
    vt[8]  = mk(1'b0, 3'b100, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 9'h155, 1'b0);
    vt[9]  = mk(1'b0, 3'b100, 3'b000, 1'b0, 3'b100, 1'b0, 3'b000, 9'h155, 1'b1);
    vt[10] = mk(1'b0, 3'b100, 3'b010, 1'b1, 3'b100, 1'b0, 3'b000, 9'h155, 1'b1);
    vt[11] = mk(1'b0, 3'b100, 3'b000, 1'b0, 3'b100, 1'b0, 3'b000, 9'h155, 1'b1);
    vt[12] = mk(1'b0, 3'b100, 3'b010, 1'b1, 3'b100, 1'b0, 3'b000, 9'h155, 1'b1);
    vt[13] = mk(1'b0, 3'b100, 3'b100, 1'b0, 3'b100, 1'b1, 3'b000, 9'h1E0, 1'b1);
    vt[14] = mk(1'b0, 3'b100, 3'b100, 1'b0, 3'b100, 1'b0, 3'b000, 9'h1E0, 1'b1);
    vt[15] = mk(1'b1, 3'b100, 3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 9'h000, 1'b0);
    vt[16] = mk(1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 3'b000, 9'h000, 1'b0);
    vt[17] = mk(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 9'h000, 1'b0);

    // Priority, stray inputs, reset mid-WAIT and late wr_done
    for (int i = 0; i < 18; i++) begin
      sys_rst = vt[i].rst; req = vt[i].req; req_valid = vt[i].vld; done_tbl = vt[i].done;
      tick();
      chk($sformatf("v%0d_gnt", i),  32'(s_gnt),  32'(vt[i].gnt));
      chk($sformatf("v%0d_en", i),   32'(s_en),   32'(vt[i].en));
      chk($sformatf("v%0d_rdy", i),  32'(s_rdy),  32'(vt[i].rdy));
      chk($sformatf("v%0d_spi", i),  32'(s_spi),  32'(vt[i].spi));
      chk($sformatf("v%0d_busy", i), 32'(s_busy), 32'(vt[i].busy));
      chk($sformatf("v%0d_terr", i), 32'(s_terr), 32'd0);
    end
    done_tbl = 1'b0;

    // Single owner, three words, non-owner valid toggling throughout
    do_reset();
    wr_lat = 20;
    noise  = 1'b1;
    req[1] = 1'b1;
    tick();
    chk("single_gnt", 32'(s_gnt), 32'(3'b010));
    xfer(2'd1, 9'h02A, 20);
    xfer(2'd1, 9'h100, 20);
    xfer(2'd1, 9'h17F, 20);
    noise = 1'b0;
    release_chk(2'd1, 1'b0, 3'b000);

    // Round-robin 1,2,1,2 then init request waits for owner 2 to release
    do_reset();
    wr_lat = 3;
    req = 3'b110;
    tick();
    chk("rr_first_gnt", 32'(s_gnt), 32'(3'b010));
    xfer(2'd1, 9'h011, 3);
    xfer(2'd1, 9'h012, 3);
    release_chk(2'd1, 1'b1, 3'b100);
    xfer(2'd2, 9'h121, 3);
    xfer(2'd2, 9'h122, 3);
    release_chk(2'd2, 1'b1, 3'b010);
    xfer(2'd1, 9'h013, 3);
    xfer(2'd1, 9'h014, 3);
    release_chk(2'd1, 1'b1, 3'b100);
    xfer(2'd2, 9'h131, 3);
    req[0] = 1'b1;
    xfer(2'd2, 9'h132, 3);
    release_chk(2'd2, 1'b1, 3'b001);
    xfer(2'd0, 9'h0F0, 3);
    release_chk(2'd0, 1'b0, 3'b010);

    // Watchdog on the TIMEOUT=16 instance
    use_t = 1'b1;
    do_reset();
    req[1] = 1'b1;
    tick();
    chk("to_gnt", 32'(s_gnt), 32'(3'b010));
    rdata[1] = 9'h0AB;
    req_valid[1] = 1'b1;
    tick();
    chk("to_en", 32'(s_en), 32'd1);
    chk("to_spi", 32'(s_spi), 32'(9'h0AB));
    bad = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      tick();
      if (s_terr !== 1'b0 || s_rdy !== 3'b000 || s_en !== 1'b0) bad = 1'b1;
    end
    chk("to_not_early", 32'(bad), 32'd0);
    tick();
    chk("to_err_set", 32'(s_terr), 32'd1);
    chk("to_no_ready", 32'(s_rdy), 32'd0);
    chk("to_rel_gnt", 32'(s_gnt), 32'(3'b010));
    req_valid[1] = 1'b0;
    req = 3'b100;
    tick();
    chk("to_idle_gnt", 32'(s_gnt), 32'd0);
    chk("to_idle_busy", 32'(s_busy), 32'd0);
    wr_lat = 5;
    tick();
    chk("to_next_gnt", 32'(s_gnt), 32'(3'b100));
    xfer(2'd2, 9'h1C4, 5);
    chk("to_sticky", 32'(s_terr), 32'd1);
    release_chk(2'd2, 1'b0, 3'b000);
    chk("to_sticky_idle", 32'(s_terr), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
